lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store controller for the MEM stage. Takes the access held in the EX/MEM register and sequences it onto the
//  data-memory request/grant/response bus. Drives byte lanes and store data, and aligns and extends load data.
//  Stalls the pipeline until the access completes. Reports misaligned accesses and bus errors/timeouts.
// PARAMETERS
//  TIMEOUT   16   cycles in REQ+WAIT with no grant/response before the access is aborted with bus_err_o
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rstn           in   1   synchronous reset, active low
//  flush_i        in   1   MEM-stage instruction is being killed this cycle
//  is_load_mem    in   1   MEM instruction is a load
//  is_store_mem   in   1   MEM instruction is a store
//  mem_op_mem     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  alu_result_mem in   32  effective byte address
//  rs2_data_mem   in   32  store source data
//  stall_o        out  1   hold IF..MEM stages (combinational)
//  load_data_o    out  32  aligned, extended load result (registered, valid in the WB cycle)
//  load_valid_o   out  1   1-cycle pulse with load_data_o
//  misalign_o     out  1   1-cycle pulse: access was misaligned, not issued
//  bus_err_o      out  1   1-cycle pulse: dmem_err_i or timeout
//  dmem_req_o     out  1   request valid
//  dmem_we_o      out  1   1 = write
//  dmem_addr_o    out  32  word address {addr[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-replicated store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   response (load data or store ack)
//  dmem_rdata_i   in   32  response data
//  dmem_err_i     in   1   response error, qualified by dmem_rvalid_i
// BEHAVIOUR
//  Reset: state IDLE, timer 0. All registered outputs are 0, including the dmem_* request regs and load_data_o.
//   Reset mid-access abandons it; dmem_req_o is low from the cycle after the reset edge.
//  access = (is_load_mem | is_store_mem) & ~flush_i.
//  Decode: ops 011/110/111 are treated as W. Unsigned variants apply to loads only.
//  Misaligned = H with addr[0]=1, or W with addr[1:0]!=0.
//  IDLE:
//   - access & misaligned: no bus request; misalign_o pulses next cycle; stall_o=0 this cycle.
//   - access & aligned: register addr/be/wdata/we; go REQ; stall_o=1.
//  REQ: dmem_req_o=1 and all request fields are held stable until the grant.
//   - dmem_gnt_i: go WAIT.
//   - flush_i before grant: drop the request; go IDLE.
//  WAIT: go IDLE on dmem_rvalid_i. Stores also wait for the ack.
//   - flush_i in WAIT: go DRAIN.
//  DRAIN: wait for dmem_rvalid_i, discard it, go IDLE. No pulses are generated.
//  stall_o = access & ~done, where done =
//   - rvalid in WAIT, or
//   - misaligned detect in IDLE, or
//   - timeout.
//   In REQ and WAIT, stall_o stays 1 through the grant cycle and drops only on done.
//   In DRAIN, stall_o = access (the new instruction waits for the drain to finish).
//  Completion (WAIT & rvalid):
//   - load & ~err: load_valid_o=1 next cycle.
//   - err: bus_err_o=1 next cycle, load_valid_o=0.
//  Timeout: timer clears on entering REQ and counts in REQ/WAIT.
//   - timer==TIMEOUT-1: done, bus_err_o pulse, dmem_req_o drops, go IDLE.
//   - A response arriving later is ignored while in IDLE.
//  Store lanes, with o = addr[1:0]:
//   - B: be = 4'b0001<<o, wdata = {4{rs2[7:0]}}
//   - H: be = 4'b0011<<o, wdata = {2{rs2[15:0]}}
//   - W: be = 4'b1111
//   Loads drive be = 4'b1111.
//  Load data: sh = rdata >> (8*o). B/H sign-extend sh[7:0]/sh[15:0]; BU/HU zero-extend; W = rdata.
//   Offset and op are taken from the registered request.
//  Back-to-back: from done, the next access may enter REQ no earlier than the cycle after IDLE is re-entered.
//  Pulse outputs are never asserted together.
// TESTING
//  1) LW addr 0x100, gnt and rvalid 1 cycle later, rdata 0xDEADBEEF -> load_data_o=0xDEADBEEF, load_valid_o 1 cycle;
//     stall_o high from access until rvalid.
//  2) SB addr 0x203, rs2=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5, we=1; no load_valid_o.
//  3) LB addr 0x2, rdata 0x00800000 -> 0xFFFFFF80. LHU addr 0x2, rdata 0x80010000 -> 0x00008001.
//  4) LW addr 0x102 -> misalign_o pulse, dmem_req_o never asserted, stall_o 0.
//     SH addr 0x101 -> same result.
//  5) gnt withheld TIMEOUT cycles -> bus_err_o pulse, req drops, back to IDLE.
//     Response with dmem_err_i=1 -> bus_err_o pulse, load_valid_o=0.
//  6) flush_i in WAIT -> DRAIN; a late rvalid is absorbed with no pulses.
//     rstn=0 during REQ -> req low next cycle, all outputs 0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller for the MEM stage. Takes the access held in the
// EX/MEM register, issues it on the data-memory req/gnt/rvalid bus, builds
// byte enables and lane-replicated store data, and aligns/extends load data.
// The pipeline (IF..MEM) is stalled until the access completes. Misaligned
// accesses are never issued; bus errors and timeouts abort the access.
//
// Parameters
//   TIMEOUT         cycles spent in REQ+WAIT without completion before abort
//
// Ports
//   clk, rstn       clock, synchronous active-low reset
//   flush_i         MEM-stage instruction is killed this cycle
//   is_load_mem     MEM instruction is a load
//   is_store_mem    MEM instruction is a store
//   mem_op_mem      funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   alu_result_mem  effective byte address
//   rs2_data_mem    store source data
//   stall_o         hold IF..MEM (combinational)
//   load_data_o     aligned/extended load result, valid with load_valid_o
//   load_valid_o    1-cycle pulse: load completed
//   misalign_o      1-cycle pulse: access misaligned, not issued
//   bus_err_o       1-cycle pulse: response error or timeout
//   dmem_*_o        request channel (req, we, word addr, byte enables, wdata)
//   dmem_*_i        grant, response valid/data/error
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic        is_load_mem,
    input  logic        is_store_mem,
    input  logic [2:0]  mem_op_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [TIMER_W-1:0] timer_q;
    logic               timer_hit;

    // Registered request context needed to finish the access.
    logic [2:0]  req_op_q;
    logic [1:0]  req_off_q;
    logic        req_load_q;

    // Incoming access decode.
    logic        access;
    logic        is_wr;
    logic [1:0]  off;
    logic        size_h;
    logic        size_w;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // FSM outputs.
    logic start;
    logic done;
    logic fire_misalign;
    logic fire_err;
    logic fire_load;

    logic [31:0] rdata_sh;
    logic [31:0] load_ext;

    assign access = (is_load_mem | is_store_mem) & ~flush_i;
    // A simultaneous load+store flag is treated as a load.
    assign is_wr  = is_store_mem & ~is_load_mem;
    assign off    = alu_result_mem[1:0];

    // op[1] set selects word (covers 010, 011, 110, 111); op[2] only marks
    // the unsigned load variants and has no effect on size.
    assign size_w = mem_op_mem[1];
    assign size_h = ~mem_op_mem[1] & mem_op_mem[0];

    assign misaligned = (size_h & off[0]) | (size_w & (off != 2'b00));

    assign timer_hit = (timer_q == TIMER_W'(TIMEOUT - 1));

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        be_d    = 4'b1111;
        wdata_d = '0;
        if (is_wr) begin
            if (size_w) begin
                be_d    = 4'b1111;
                wdata_d = rs2_data_mem;
            end else if (size_h) begin
                be_d    = 4'b0011 << off;
                wdata_d = {2{rs2_data_mem[15:0]}};
            end else begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{rs2_data_mem[7:0]}};
            end
        end
    end

    // Next-state logic and completion events.
    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        done          = 1'b0;
        fire_misalign = 1'b0;
        fire_err      = 1'b0;
        fire_load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        done          = 1'b1;
                        fire_misalign = 1'b1;
                    end else begin
                        start   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                // A grant takes precedence: once the bus has accepted the
                // request a response is owed, so a flush in the same cycle
                // must drain it rather than drop it.
                if (dmem_gnt_i) begin
                    state_d = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end else if (timer_hit) begin
                    done     = 1'b1;
                    fire_err = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    // A response in the flush cycle is consumed silently;
                    // waiting in DRAIN for a second one would never end.
                    state_d = S_IDLE;
                    if (!flush_i) begin
                        done = 1'b1;
                        if (dmem_err_i) begin
                            fire_err = 1'b1;
                        end else if (req_load_q) begin
                            fire_load = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end else if (timer_hit) begin
                    done     = 1'b1;
                    fire_err = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (dmem_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // In DRAIN done is never set, so a new access simply waits.
    assign stall_o = access & ~done;

    // Load alignment and extension from the registered request.
    always_comb begin
        rdata_sh = dmem_rdata_i >> {req_off_q, 3'b000};
        if (req_op_q[1]) begin
            load_ext = dmem_rdata_i;
        end else if (req_op_q[0]) begin
            load_ext = req_op_q[2] ? {16'h0000, rdata_sh[15:0]}
                                   : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
        end else begin
            load_ext = req_op_q[2] ? {24'h000000, rdata_sh[7:0]}
                                   : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request channel, timer and result registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer_q      <= '0;
            req_op_q     <= '0;
            req_off_q    <= '0;
            req_load_q   <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            // The request is visible exactly while the FSM sits in REQ.
            dmem_req_o <= (state_d == S_REQ);

            if (start) begin
                timer_q      <= '0;
                req_op_q     <= mem_op_mem;
                req_off_q    <= off;
                req_load_q   <= ~is_wr;
                dmem_we_o    <= is_wr;
                dmem_addr_o  <= {alu_result_mem[31:2], 2'b00};
                dmem_be_o    <= be_d;
                dmem_wdata_o <= wdata_d;
            end else if ((state_q == S_REQ || state_q == S_WAIT) && !timer_hit) begin
                // Saturates so a grant on the last allowed cycle still
                // leaves the access at its limit in WAIT.
                timer_q <= timer_q + 1'b1;
            end

            load_valid_o <= fire_load;
            misalign_o   <= fire_misalign;
            bus_err_o    <= fire_err;
            if (fire_load) begin
                load_data_o <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush_i;
    logic        is_load_mem;
    logic        is_store_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] rs2_data_mem;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_err_i;

    int total = 0;
    int bad   = 0;

    lsu_mem_ctrl #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush_i        (flush_i),
        .is_load_mem    (is_load_mem),
        .is_store_mem   (is_store_mem),
        .mem_op_mem     (mem_op_mem),
        .alu_result_mem (alu_result_mem),
        .rs2_data_mem   (rs2_data_mem),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .load_valid_o   (load_valid_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_err_i     (dmem_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic        is_store;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        err;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_lv;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        is_load_mem  = 1'b0;
        is_store_mem = 1'b0;
        flush_i      = 1'b0;
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input logic err, input logic mis,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] data, input logic lv, input logic berr);
        vec_t v;
        v.is_load = ld;   v.is_store = st;  v.op = op;       v.addr = addr;
        v.rs2 = rs2;      v.rdata = rdata;  v.err = err;     v.exp_mis = mis;
        v.exp_be = be;    v.exp_wdata = wdata; v.exp_data = data;
        v.exp_lv = lv;    v.exp_err = berr;
        return v;
    endfunction

    // One access: 1 IDLE cycle, 1 REQ cycle with grant, 1 WAIT cycle with response.
    task automatic run_vec(input int i, input vec_t v);
        is_load_mem    = v.is_load;
        is_store_mem   = v.is_store;
        mem_op_mem     = v.op;
        alu_result_mem = v.addr;
        rs2_data_mem   = v.rs2;
        @(negedge clk);
        if (v.exp_mis) begin
            check($sformatf("v%0d_mis_stall", i), stall_o, 0);
            check($sformatf("v%0d_mis_req0", i), dmem_req_o, 0);
            step();
            idle_inputs();
            @(negedge clk);
            check($sformatf("v%0d_misalign", i), misalign_o, 1);
            check($sformatf("v%0d_mis_req1", i), dmem_req_o, 0);
            check($sformatf("v%0d_mis_err", i), bus_err_o, 0);
            step();
            @(negedge clk);
            check($sformatf("v%0d_misalign_clr", i), misalign_o, 0);
        end else begin
            check($sformatf("v%0d_stall_idle", i), stall_o, 1);
            step();
            dmem_gnt_i = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_req", i), dmem_req_o, 1);
            check($sformatf("v%0d_addr", i), dmem_addr_o, v.addr & 32'hFFFF_FFFC);
            check($sformatf("v%0d_be", i), dmem_be_o, v.exp_be);
            check($sformatf("v%0d_we", i), dmem_we_o, v.is_store & ~v.is_load);
            if (v.is_store) check($sformatf("v%0d_wdata", i), dmem_wdata_o, v.exp_wdata);
            check($sformatf("v%0d_stall_gnt", i), stall_o, 1);
            step();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = v.rdata;
            dmem_err_i    = v.err;
            @(negedge clk);
            check($sformatf("v%0d_stall_done", i), stall_o, 0);
            check($sformatf("v%0d_req_wait", i), dmem_req_o, 0);
            step();
            dmem_rvalid_i = 1'b0;
            dmem_err_i    = 1'b0;
            idle_inputs();
            @(negedge clk);
            check($sformatf("v%0d_lv", i), load_valid_o, v.exp_lv);
            check($sformatf("v%0d_buserr", i), bus_err_o, v.exp_err);
            check($sformatf("v%0d_mis0", i), misalign_o, 0);
            if (v.exp_lv) check($sformatf("v%0d_data", i), load_data_o, v.exp_data);
            step();
            @(negedge clk);
            check($sformatf("v%0d_lv_clr", i), load_valid_o, 0);
            check($sformatf("v%0d_err_clr", i), bus_err_o, 0);
        end
        step();
    endtask

    initial begin
        int cnt;
        logic last_stall;

        rstn = 1'b0;
        idle_inputs();
        mem_op_mem     = 3'b000;
        alu_result_mem = '0;
        rs2_data_mem   = '0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = '0;
        dmem_err_i     = 1'b0;

        //            ld st op      addr          rs2           rdata         er mis be       wdata         data          lv be
        vecs[0]  = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 0);
        vecs[1]  = mk(0, 1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0);
        vecs[2]  = mk(1, 0, 3'b000, 32'h0000_0002, 32'h0,        32'h0080_0000, 0, 0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1, 0);
        vecs[3]  = mk(1, 0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 0, 4'b1111, 32'h0,        32'h0000_8001, 1, 0);
        vecs[4]  = mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 0);
        vecs[5]  = mk(0, 1, 3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(1, 0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_F00D, 0, 0, 4'b1111, 32'h0,        32'hFFFF_F00D, 1, 0);
        vecs[7]  = mk(1, 0, 3'b100, 32'h0000_0003, 32'h0,        32'hC300_0000, 0, 0, 4'b1111, 32'h0,        32'h0000_00C3, 1, 0);
        vecs[8]  = mk(0, 1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0);
        vecs[9]  = mk(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0);
        vecs[10] = mk(1, 0, 3'b010, 32'h0000_0020, 32'h0,        32'h1111_2222, 1, 0, 4'b1111, 32'h0,        32'h0,        0, 1);
        vecs[11] = mk(1, 0, 3'b111, 32'h0000_0010, 32'h0,        32'h1122_3344, 0, 0, 4'b1111, 32'h0,        32'h1122_3344, 1, 0);
        vecs[12] = mk(0, 1, 3'b011, 32'h0000_0002, 32'h5555_5555, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 0);
        vecs[13] = mk(1, 0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_AB00, 0, 0, 4'b1111, 32'h0,        32'h0000_00AB, 1, 0);

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check("rst_req", dmem_req_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_data", load_data_o, 0);
        check("rst_pulses", {misalign_o, bus_err_o, load_valid_o}, 0);
        check("rst_stall", stall_o, 0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Timeout: grant withheld; request must last exactly 16 cycles.
        is_load_mem    = 1'b1;
        mem_op_mem     = 3'b010;
        alu_result_mem = 32'h0000_0040;
        step();
        cnt        = 0;
        last_stall = 1'b1;
        while (dmem_req_o && cnt < 40) begin
            cnt++;
            @(negedge clk);
            last_stall = stall_o;
            step();
        end
        idle_inputs();
        check("to_cycles", cnt, 16);
        check("to_last_stall", last_stall, 0);
        check("to_buserr", bus_err_o, 1);
        check("to_lv", load_valid_o, 0);
        check("to_req_low", dmem_req_o, 0);
        // Late response while IDLE is ignored.
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h9999_9999;
        step();
        dmem_rvalid_i = 1'b0;
        check("to_err_clr", bus_err_o, 0);
        step();
        check("late_rsp_pulses", {misalign_o, bus_err_o, load_valid_o}, 0);

        // Flush in WAIT -> DRAIN; next access waits, then issues back-to-back.
        is_load_mem    = 1'b1;
        mem_op_mem     = 3'b010;
        alu_result_mem = 32'h0000_0080;
        step();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        @(negedge clk);
        check("fl_wait_stall", stall_o, 0);
        step();
        flush_i        = 1'b0;
        alu_result_mem = 32'h0000_0084;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d_stall", k), stall_o, 1);
            check($sformatf("drain%0d_req", k), dmem_req_o, 0);
            step();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0000_0055;
        @(negedge clk);
        check("drain_rsp_stall", stall_o, 1);
        step();
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("drain_pulses", {misalign_o, bus_err_o, load_valid_o}, 0);
        check("drain_idle_req", dmem_req_o, 0);
        step();
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        check("b2b_req", dmem_req_o, 1);
        check("b2b_addr", dmem_addr_o, 32'h0000_0084);
        step();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h7777_7777;
        step();
        dmem_rvalid_i = 1'b0;
        idle_inputs();
        check("b2b_lv", load_valid_o, 1);
        check("b2b_data", load_data_o, 32'h7777_7777);
        step();

        // Flush in REQ before grant: request dropped, no pulses.
        is_store_mem   = 1'b1;
        mem_op_mem     = 3'b010;
        alu_result_mem = 32'h0000_0500;
        rs2_data_mem   = 32'h0BAD_F00D;
        step();
        check("flreq_req", dmem_req_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        check("flreq_stall", stall_o, 0);
        step();
        idle_inputs();
        check("flreq_req_low", dmem_req_o, 0);
        step();
        check("flreq_pulses", {misalign_o, bus_err_o, load_valid_o}, 0);

        // Reset during REQ: everything registered clears next cycle.
        is_load_mem    = 1'b1;
        mem_op_mem     = 3'b010;
        alu_result_mem = 32'h0000_0444;
        step();
        check("rreq_req", dmem_req_o, 1);
        rstn = 1'b0;
        idle_inputs();
        step();
        check("rreq_req_low", dmem_req_o, 0);
        check("rreq_addr", dmem_addr_o, 0);
        check("rreq_be", dmem_be_o, 0);
        check("rreq_data", load_data_o, 0);
        check("rreq_pulses", {misalign_o, bus_err_o, load_valid_o}, 0);
        rstn = 1'b1;
        step();
        check("rreq_stays_idle", dmem_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
